spi_ctrl_session: RTL and testbench

Session controller for the test-shield SPI control channel. It sits behind the SPI key detector: it waits for the detector's one-cycle match pulse, then decodes a command, address and length header from the same mode-0 SPI stream. It then runs a burst of register-bus writes, or reads whose data it shifts back out on `sout`. `sin` and `sclk` are already synchronized to `clk` upstream.

---
 rtl/spi_ctrl_session.sv | 166 ++++++++++++++++
 tb/tb_spi_ctrl_session.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ctrl_session.sv
// SPI control-channel session: CMD/ADDR/LEN header, then burst register writes or reads.
// Optional macro SPI_CTRL_AUTOINC_EN: reg_addr increments after every strobe.
module spi_ctrl_session #(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sin,
   input  logic       sclk,
   input  logic       match,
   output logic       sout,
   output logic       active,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_HUNT,
      S_CMD,
      S_ADDR,
      S_LEN,
      S_WRITE,
      S_READ
   } state_t;

   state_t r_state;
   state_t w_next;

   logic          r_sclk_prev;
   logic          r_op_rd;
   logic          r_wr;
   logic          r_rd;
   logic          r_rd_d;
   logic [2:0]    r_bitcnt;
   logic [6:0]    r_rx;
   logic [7:0]    r_tx;
   logic [7:0]    r_addr;
   logic [7:0]    r_wdata;
   logic [8:0]    r_len;
   logic [TW-1:0] r_tmo;

   logic       w_pos;
   logic       w_neg;
   logic       w_done;
   logic       w_tmo;
   logic [7:0] w_byte;

   assign w_pos  = sclk & ~r_sclk_prev;
   assign w_neg  = ~sclk & r_sclk_prev;
   assign w_done = w_pos && (r_bitcnt == 3'd7) && (r_state != S_HUNT);
   assign w_tmo  = (r_tmo == TW'(TIMEOUT_CYCLES));
   assign w_byte = {r_rx, sin};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_HUNT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_HUNT: begin
            if (match) w_next = S_CMD;
         end
         S_CMD: begin
            if (w_done) begin
               if (w_byte[7:1] == 7'd0) w_next = S_ADDR;
               else w_next = S_HUNT;
            end
         end
         S_ADDR: begin
            if (w_done) w_next = S_LEN;
         end
         S_LEN: begin
            if (w_done) w_next = r_op_rd ? S_READ : S_WRITE;
         end
         S_WRITE: begin
            // leave only once the final strobe is on the bus
            if (r_wr && r_len == 9'd0) w_next = S_HUNT;
         end
         S_READ: begin
            if (w_done && r_len == 9'd1) w_next = S_HUNT;
         end
         default: w_next = S_HUNT;
      endcase
      if (r_state != S_HUNT && w_tmo) w_next = S_HUNT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_prev <= 1'b0;
         r_op_rd     <= 1'b0;
         r_wr        <= 1'b0;
         r_rd        <= 1'b0;
         r_rd_d      <= 1'b0;
         r_bitcnt    <= 3'd0;
         r_rx        <= 7'd0;
         r_tx        <= 8'd0;
         r_addr      <= 8'd0;
         r_wdata     <= 8'd0;
         r_len       <= 9'd0;
         r_tmo       <= '0;
      end else begin
         r_sclk_prev <= sclk;
         r_wr        <= 1'b0;
         r_rd        <= 1'b0;
         r_rd_d      <= r_rd;

         if (r_state == S_HUNT || w_pos || w_neg) r_tmo <= '0;
         else if (!w_tmo) r_tmo <= r_tmo + 1'b1;

         if (r_state == S_HUNT) begin
            if (match) r_bitcnt <= 3'd0;
         end else if (w_pos) begin
            r_bitcnt <= r_bitcnt + 3'd1;
            r_rx     <= w_byte[6:0];
         end

         if (w_done) begin
            unique case (r_state)
               S_CMD: r_op_rd <= w_byte[0];
               S_ADDR: r_addr <= w_byte;
               S_LEN: begin
                  r_len <= {w_byte == 8'd0, w_byte};
                  r_rd  <= r_op_rd;
               end
               S_WRITE: begin
                  r_wdata <= w_byte;
                  r_wr    <= 1'b1;
                  r_len   <= r_len - 9'd1;
               end
               S_READ: begin
                  r_len <= r_len - 9'd1;
                  r_rd  <= (r_len != 9'd1);
               end
               default: ;
            endcase
         end

         // the neg right after a byte boundary must keep the new byte
         if (r_rd_d) r_tx <= reg_rdata;
         else if (r_state == S_READ && w_neg && r_bitcnt != 3'd0)
            r_tx <= {r_tx[6:0], 1'b0};

`ifdef SPI_CTRL_AUTOINC_EN
         if (r_wr || r_rd) r_addr <= r_addr + 8'd1;
`endif
      end
   end

   assign sout      = (r_state == S_READ) & r_tx[7];
   assign active    = (r_state != S_HUNT);
   assign reg_addr  = r_addr;
   assign reg_wdata = r_wdata;
   assign reg_wr    = r_wr & ~rst;
   assign reg_rd    = r_rd & ~rst;

endmodule

// File: tb/tb_spi_ctrl_session.sv
// Directed bench for spi_ctrl_session: table of sessions plus timeout,
// wrap/length-0 and reset-mid-read sequences.
module tb_spi_ctrl_session;

   localparam int TMO = 200;
`ifdef SPI_CTRL_AUTOINC_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sin = 1'b0;
   logic       sclk = 1'b0;
   logic       match = 1'b0;
   logic       sout;
   logic       active;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_rdata = 8'd0;

   always #5 clk = ~clk;

   spi_ctrl_session #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .sclk      (sclk),
      .match     (match),
      .sout      (sout),
      .active    (active),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rd    (reg_rd),
      .reg_rdata (reg_rdata)
   );

   int         n_wr = 0;
   int         n_rd = 0;
   logic [7:0] wa[512];
   logic [7:0] wdat[512];

   // register bus model: read data is addr^FF, one cycle after reg_rd
   always @(posedge clk) begin
      if (reg_wr && n_wr < 512) begin
         wa[n_wr]   <= reg_addr;
         wdat[n_wr] <= reg_wdata;
         n_wr       <= n_wr + 1;
      end
      if (reg_rd) begin
         n_rd      <= n_rd + 1;
         reg_rdata <= reg_addr ^ 8'hFF;
      end
   end

   int n_tot = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic bit_x(input logic b, output logic so);
      sin = b;
      repeat (4) @(negedge clk);
      so = sout;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic byte_x(input logic [7:0] b, output logic [7:0] r);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_x(b[i], s);
         r[i] = s;
      end
   endtask

   task automatic send(input logic [7:0] b);
      logic [7:0] d;
      byte_x(b, d);
   endtask

   task automatic key();
      @(negedge clk) match = 1'b1;
      @(negedge clk) match = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  cmd;
      logic [7:0]  addr;
      logic [7:0]  len;
      int          hdr;
      int          nb;
      logic [23:0] dat;
      int          ewr;
      int          erd;
      logic [23:0] erx;
      logic [7:0]  ea0;
   } vec_t;

   vec_t vt[5];

   initial begin
      int bw, br, bad;
      logic [7:0] r;
      logic s;
      logic [7:0] ex;

      vt[0] = '{8'h00, 8'h10, 8'h03, 3, 3, 24'hAABBCC, 3, 0, 24'h0, 8'h10};
      vt[1] = '{8'h01, 8'h20, 8'h02, 3, 2, 24'h0, 0, 2,
                (AUTO ? 24'hDFDE00 : 24'hDFDF00), 8'h20};
      vt[2] = '{8'h7E, 8'h00, 8'h00, 1, 1, 24'h0, 0, 0, 24'h0, 8'h00};
      vt[3] = '{8'h00, 8'h33, 8'h01, 3, 1, 24'h5A0000, 1, 0, 24'h0, 8'h33};
      vt[4] = '{8'h01, 8'hFF, 8'h01, 3, 1, 24'h0, 0, 1, 24'h000000, 8'hFF};

      repeat (3) @(negedge clk);
      chk("rst_active", active, 0);
      chk("rst_sout", sout, 0);
      chk("rst_addr", reg_addr, 0);
      chk("rst_wdata", reg_wdata, 0);
      chk("rst_wr", reg_wr, 0);
      chk("rst_rd", reg_rd, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         bw = n_wr;
         br = n_rd;
         key();
         chk($sformatf("v%0d_active_up", v), active, 1);
         send(vt[v].cmd);
         if (vt[v].hdr == 3) begin
            send(vt[v].addr);
            send(vt[v].len);
         end else begin
            chk($sformatf("v%0d_badcmd_hunt", v), active, 0);
         end
         for (int i = 0; i < vt[v].nb; i++) begin
            if (vt[v].hdr == 3 && i == vt[v].nb - 1)
               chk($sformatf("v%0d_active_before_last", v), active, 1);
            byte_x(vt[v].dat[23-8*i -: 8], r);
            if (vt[v].erd > 0)
               chk($sformatf("v%0d_rx%0d", v, i), r, vt[v].erx[23-8*i -: 8]);
         end
         repeat (4) @(negedge clk);
         chk($sformatf("v%0d_active_end", v), active, 0);
         chk($sformatf("v%0d_nwr", v), n_wr - bw, vt[v].ewr);
         chk($sformatf("v%0d_nrd", v), n_rd - br, vt[v].erd);
         for (int i = 0; i < vt[v].ewr; i++) begin
            ex = vt[v].ea0 + (AUTO ? 8'(i) : 8'd0);
            chk($sformatf("v%0d_waddr%0d", v, i), wa[bw+i], ex);
            chk($sformatf("v%0d_wdata%0d", v, i), wdat[bw+i], vt[v].dat[23-8*i -: 8]);
         end
      end

      // timeout with a half-received address byte
      bw = n_wr;
      key();
      send(8'h00);
      for (int i = 0; i < 4; i++) bit_x(1'b1, s);
      repeat (TMO - 10) @(negedge clk);
      chk("tmo_still_active", active, 1);
      repeat (20) @(negedge clk);
      chk("tmo_hunt", active, 0);
      send(8'h00);
      send(8'h05);
      send(8'h01);
      send(8'h11);
      chk("tmo_no_restart", active, 0);
      chk("tmo_no_wr", n_wr - bw, 0);

      // length 0 means 256 bytes, address wraps past FF
      bw = n_wr;
      key();
      send(8'h00);
      send(8'hFE);
      send(8'h00);
      for (int i = 0; i < 256; i++) send(8'(i));
      repeat (4) @(negedge clk);
      chk("wrap_nwr", n_wr - bw, 256);
      chk("wrap_active", active, 0);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         ex = AUTO ? 8'(8'hFE + i) : 8'hFE;
         if (wa[bw+i] !== ex || wdat[bw+i] !== 8'(i)) bad++;
      end
      chk("wrap_bad_strobes", bad, 0);
      chk("wrap_last_addr", wa[bw+255], AUTO ? 8'hFD : 8'hFE);

      // reset in the middle of a read data byte
      br = n_rd;
      key();
      send(8'h01);
      send(8'h40);
      send(8'h05);
      byte_x(8'h00, r);
      chk("rrst_first_byte", r, 8'hBF);
      for (int i = 0; i < 3; i++) bit_x(1'b0, s);
      chk("rrst_nrd_before", n_rd - br, 2);
      rst = 1'b1;
      @(negedge clk);
      chk("rrst_active", active, 0);
      chk("rrst_sout", sout, 0);
      rst = 1'b0;
      br = n_rd;
      for (int i = 0; i < 13; i++) bit_x(1'b0, s);
      repeat (4) @(negedge clk);
      chk("rrst_no_rd", n_rd - br, 0);
      bw = n_wr;
      key();
      send(8'h00);
      send(8'h50);
      send(8'h01);
      send(8'h77);
      repeat (4) @(negedge clk);
      chk("rrst_new_nwr", n_wr - bw, 1);
      chk("rrst_new_addr", wa[bw], 8'h50);
      chk("rrst_new_data", wdat[bw], 8'h77);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
